// File: rtl/qam16_pkg.sv
// Shared constants for the 16-QAM demodulator: carrier tables, level codes, FSM states.
package qam16_pkg;

    localparam int SMP_W   = 13;
    localparam int CAR_W   = 10;
    localparam int CAR_PTS = 16;

    localparam logic [1:0] LVL_N3 = 2'b00;
    localparam logic [1:0] LVL_N1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b10;
    localparam logic [1:0] LVL_P3 = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, SLICE} state_t;

    // One carrier period, peak 511; must match the modulator's carrier generator.
    localparam logic signed [CAR_W-1:0] COS_TAB [CAR_PTS] = '{
         10'sd511,  10'sd472,  10'sd361,  10'sd196,
         10'sd0,   -10'sd196, -10'sd361, -10'sd472,
        -10'sd511, -10'sd472, -10'sd361, -10'sd196,
         10'sd0,    10'sd196,  10'sd361,  10'sd472
    };

    localparam logic signed [CAR_W-1:0] SIN_TAB [CAR_PTS] = '{
         10'sd0,    10'sd196,  10'sd361,  10'sd472,
         10'sd511,  10'sd472,  10'sd361,  10'sd196,
         10'sd0,   -10'sd196, -10'sd361, -10'sd472,
        -10'sd511, -10'sd472, -10'sd361, -10'sd196
    };

endpackage

// File: rtl/qam16_slicer.sv
// Four-level decision for one axis: compares an integrated sum against +/-thresh.
module qam16_slicer
    import qam16_pkg::*;
#(
    parameter int ACC_W = 31
) (
    input  logic signed [ACC_W-1:0] sum,
    input  logic        [ACC_W-2:0] thresh,
    output logic        [1:0]       level
);

    logic signed [ACC_W-1:0] t_pos;
    logic signed [ACC_W-1:0] t_neg;

    always_comb begin
        t_pos = signed'({1'b0, thresh});
        t_neg = -t_pos;
        if (sum >= t_pos)
            level = LVL_P3;
        else if (!sum[ACC_W-1])
            level = LVL_P1;
        else if (sum > t_neg)
            level = LVL_N1;
        else
            level = LVL_N3;
    end

endmodule

// File: rtl/qam16_demodulator.sv
// Coherent 16-QAM demodulator: carrier correlation, integrate-and-dump, slicing, serialiser.
// Optional PRBS bit checker enabled by defining QAM_DEMOD_PRBS_CHK_EN.
module qam16_demodulator
    import qam16_pkg::*;
#(
    parameter int SPS   = 32,
    parameter int ACC_W = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic signed [SMP_W-1:0] sample,
    input  logic                    sym_start,
    input  logic        [ACC_W-2:0] thresh,
    output logic                    sym_valid,
    output logic        [1:0]       sym_i,
    output logic        [1:0]       sym_q,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    overrun,
    output logic                    locked
`ifdef QAM_DEMOD_PRBS_CHK_EN
    ,
    input  logic                    chk_clr,
    output logic        [15:0]      err_cnt
`endif
);

    localparam int CNT_W = $clog2(SPS);
    localparam int PH_W  = $clog2(CAR_PTS);
    localparam int PRD_W = SMP_W + CAR_W;

    function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [SMP_W-1:0] s,
                                                        input logic signed [CAR_W-1:0] c);
        logic signed [PRD_W-1:0] p;
        p = s * c;
        return {{(ACC_W-PRD_W){p[PRD_W-1]}}, p};
    endfunction

    // Input register stage keeps the multipliers off the pin timing path.
    logic                    in_vld, in_start;
    logic signed [SMP_W-1:0] in_smp;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [PH_W-1:0]         phase;
    logic signed [ACC_W-1:0] acc_i, acc_q, dump_i, dump_q;
    logic signed [ACC_W-1:0] t_i, t_q, t0_i, t0_q;
    logic [1:0]              lvl_i, lvl_q;
    logic                    last;
    logic [3:0]              ser_sh;
    logic [2:0]              ser_cnt;

    // SPS is a whole number of carrier periods, so the phase is the low bits of cnt.
    assign phase = cnt[PH_W-1:0];
    assign last  = (cnt == CNT_W'(SPS-1));

    always_comb begin
        t_i  = mul_ext(in_smp, COS_TAB[phase]);
        t_q  = -mul_ext(in_smp, SIN_TAB[phase]);
        t0_i = mul_ext(in_smp, COS_TAB[0]);
        t0_q = -mul_ext(in_smp, SIN_TAB[0]);
    end

    qam16_slicer #(.ACC_W(ACC_W)) u_slice_i (.sum(dump_i), .thresh(thresh), .level(lvl_i));
    qam16_slicer #(.ACC_W(ACC_W)) u_slice_q (.sum(dump_q), .thresh(thresh), .level(lvl_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_vld   <= 1'b0;
            in_start <= 1'b0;
            in_smp   <= '0;
        end else begin
            in_vld   <= sample_en;
            in_start <= sample_en & sym_start;
            in_smp   <= sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            dump_i    <= '0;
            dump_q    <= '0;
            sym_valid <= 1'b0;
            sym_i     <= '0;
            sym_q     <= '0;
            locked    <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (state == SLICE) begin
                sym_valid <= 1'b1;
                sym_i     <= lvl_i;
                sym_q     <= lvl_q;
                state     <= ACCUM;
            end
            if (in_vld) begin
                if (state == IDLE) begin
                    if (in_start) begin
                        locked <= 1'b1;
                        acc_i  <= t0_i;
                        acc_q  <= t0_q;
                        cnt    <= CNT_W'(1);
                        state  <= ACCUM;
                    end
                end else begin
                    // A start on the final sample still dumps the completed symbol.
                    if (last) begin
                        dump_i <= acc_i + t_i;
                        dump_q <= acc_q + t_q;
                        state  <= SLICE;
                    end
                    if (in_start) begin
                        acc_i <= t0_i;
                        acc_q <= t0_q;
                        cnt   <= CNT_W'(1);
                    end else if (last) begin
                        acc_i <= '0;
                        acc_q <= '0;
                        cnt   <= '0;
                    end else begin
                        acc_i <= acc_i + t_i;
                        acc_q <= acc_q + t_q;
                        cnt   <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Serialiser loads on the sym_valid edge and emits MSB-first over the next 4 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_sh    <= '0;
            ser_cnt   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (state == SLICE) begin
            overrun   <= overrun | (ser_cnt != 3'd0);
            ser_sh    <= {lvl_i, lvl_q};
            ser_cnt   <= 3'd4;
            bit_valid <= 1'b0;
        end else if (ser_cnt != 3'd0) begin
            bit_out   <= ser_sh[3];
            bit_valid <= 1'b1;
            ser_sh    <= {ser_sh[2:0], 1'b0};
            ser_cnt   <= ser_cnt - 3'd1;
        end else begin
            bit_valid <= 1'b0;
        end
    end

`ifdef QAM_DEMOD_PRBS_CHK_EN
    // Self-synchronising x^3+x+1 checker: predicts s[n] = s[n-2] ^ s[n-3].
    logic [2:0] chk_hist;
    logic [1:0] chk_seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_hist <= '0;
            chk_seed <= '0;
            err_cnt  <= '0;
        end else begin
            if (chk_clr)
                err_cnt <= '0;
            if (bit_valid) begin
                chk_hist <= {chk_hist[1:0], bit_out};
                if (chk_seed != 2'd3)
                    chk_seed <= chk_seed + 2'd1;
                else if (!chk_clr && (bit_out != (chk_hist[1] ^ chk_hist[2])) && (err_cnt != 16'hFFFF))
                    err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
